atom_issue_stage: RTL and testbench
===================================

ATOM_ISSUE_STAGE -- requirements
Module: atom_issue_stage

Interface
REQ-001 Parameter: COUNT_WIDTH, 32, width of packet field, constant and atom state.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i__in_valid  input  1  upstream packet valid.
REQ-005 o__in_ready  output  1  block can accept a packet.
REQ-006 i__in_pkt  input  COUNT_WIDTH  packet field operand.
REQ-007 i__in_sel1, i__in_sel2  input  1 each  per-packet atom opcode bits.
REQ-008 i__cfg_constant  input  COUNT_WIDTH  static constant operand; quasi-static.
REQ-009 o__atom_constant, o__atom_pkt_1  output  COUNT_WIDTH  drive read-add-write atom operands.
REQ-010 o__atom_sel1, o__atom_sel2  output  1  drive atom selects.
REQ-011 i__atom_read, i__atom_write  input  COUNT_WIDTH  atom pre-state and new-state (combinational from atom).
REQ-012 o__out_valid  output  1  result valid; i__out_ready  input  1  downstream accepts.
REQ-013 o__out_read, o__out_write  output  COUNT_WIDTH  registered result pair.

Function
REQ-014 Input buffer SHALL be a 2-entry FIFO; o__in_ready = not full, independent of same-cycle pop.
REQ-015 Push SHALL occur when i__in_valid & o__in_ready; pkt, sel1, sel2 stored together.
REQ-016 Issue SHALL occur in a cycle when FIFO non-empty and (o__out_valid==0 or i__out_ready==1).
REQ-017 On issue, atom outputs SHALL be i__cfg_constant, head pkt, head sel1, head sel2; head popped at that edge.
REQ-018 On issue, i__atom_read/i__atom_write SHALL be captured into o__out_read/o__out_write and o__out_valid set at that edge.
REQ-019 When not issuing, atom outputs SHALL be the no-op (constant 0, pkt 0, sel1 0, sel2 0) so atom state is held (write = 0 + state).
REQ-020 o__out_valid SHALL clear on i__out_ready & o__out_valid with no same-cycle issue; results held stable while valid & !ready.
REQ-021 Latency: packet accepted at edge N SHALL issue no earlier than cycle N+1; o__out_valid earliest after edge N+1.
REQ-022 Simultaneous push and pop SHALL keep occupancy unchanged; push to empty FIFO never bypasses to issue same cycle.
REQ-023 Packets SHALL issue strictly in arrival order; no packet dropped or duplicated.
REQ-024 Arithmetic is performed by the atom; block SHALL not modify operand or result widths (mod 2^COUNT_WIDTH wrap passes through).

Reset
REQ-025 rst_n low SHALL asynchronously empty FIFO, clear o__out_valid, zero o__out_read/o__out_write.
REQ-026 During and after reset, o__in_ready SHALL be 1 and atom outputs SHALL be the no-op.
REQ-027 Reset mid-operation SHALL discard buffered and pending-result packets; atom state is not reset by this block.

Configuration
REQ-028 Macro ATOM_ISSUE_STAGE_STATS_EN defined: SHALL add output o__issue_count (32 bits), +1 per issue, wraps 0xFFFFFFFF->0, reset 0.
REQ-029 Macro undefined: o__issue_count port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-030 Atom state 7, constant 5, push pkt 10 sel1=1 sel2=0 -> out_read 7, out_write 17 two cycles after accept.
REQ-031 Atom state 17, push pkt 99 sel1=0 sel2=1 -> out_write 5 (constant only), out_read 17; state becomes 5.
REQ-032 out_ready held 0, push 4 back-to-back -> 3 accepted (1 result + 2 FIFO), in_ready 0; release -> results in order.
REQ-033 No input for 10 cycles with state 42 -> atom sees no-op every cycle, state stays 42, out_valid 0.
REQ-034 Assert rst_n low with 2 buffered + 1 pending -> out_valid 0, in_ready 1 immediately; no stale result after release.
REQ-035 With STATS_EN, counter preset near 0xFFFFFFFF via 2 issues -> reads 0x00000000 after wrap.

Source files
------------

// File: rtl/atom_issue_stage_if.sv
// Packet-in / result-out bus of atom_issue_stage.
// Both streams use valid/ready: a beat transfers on a rising clk edge where
// valid and ready are both high; the producer holds valid and payload stable
// until that edge, and ready may be asserted independently of valid.
interface atom_issue_stage_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   i__in_valid;
  logic                   o__in_ready;
  logic [COUNT_WIDTH-1:0] i__in_pkt;
  logic                   i__in_sel1;
  logic                   i__in_sel2;
  logic                   o__out_valid;
  logic                   i__out_ready;
  logic [COUNT_WIDTH-1:0] o__out_read;
  logic [COUNT_WIDTH-1:0] o__out_write;

  modport slave (
    input  i__in_valid, i__in_pkt, i__in_sel1, i__in_sel2, i__out_ready,
    output o__in_ready, o__out_valid, o__out_read, o__out_write
  );

  modport master (
    output i__in_valid, i__in_pkt, i__in_sel1, i__in_sel2, i__out_ready,
    input  o__in_ready, o__out_valid, o__out_read, o__out_write
  );
endinterface

// File: rtl/atom_issue_stage.sv
// Issue stage for a read-add-write atom: 2-entry packet FIFO, one issue per
// cycle, registered result pair. Define ATOM_ISSUE_STAGE_STATS_EN for o__issue_count.
module atom_issue_stage #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  atom_issue_stage_if.slave      bus,
  input  logic [COUNT_WIDTH-1:0] i__cfg_constant,
  output logic [COUNT_WIDTH-1:0] o__atom_constant,
  output logic [COUNT_WIDTH-1:0] o__atom_pkt_1,
  output logic                   o__atom_sel1,
  output logic                   o__atom_sel2,
  input  logic [COUNT_WIDTH-1:0] i__atom_read,
  input  logic [COUNT_WIDTH-1:0] i__atom_write
`ifdef ATOM_ISSUE_STAGE_STATS_EN
  ,
  output logic [31:0]            o__issue_count
`endif
);

  logic [COUNT_WIDTH-1:0] pkt_mem  [2];
  logic                   sel1_mem [2];
  logic                   sel2_mem [2];
  logic                   wr_ptr;
  logic                   rd_ptr;
  logic [1:0]             count;
  logic                   push;
  logic                   issue;
  logic                   out_valid_q;
  logic [COUNT_WIDTH-1:0] out_read_q;
  logic [COUNT_WIDTH-1:0] out_write_q;

  // Ready depends only on occupancy, so a full FIFO refuses even when popping.
  assign bus.o__in_ready = (count != 2'd2);
  assign push  = bus.i__in_valid && bus.o__in_ready;
  assign issue = (count != 2'd0) && (!out_valid_q || bus.i__out_ready);

  always_ff @(posedge clk) begin
    if (push) begin
      pkt_mem[wr_ptr]  <= bus.i__in_pkt;
      sel1_mem[wr_ptr] <= bus.i__in_sel1;
      sel2_mem[wr_ptr] <= bus.i__in_sel2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push)  wr_ptr <= ~wr_ptr;
      if (issue) rd_ptr <= ~rd_ptr;
      case ({push, issue})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Idle cycles drive an all-zero operand set so the atom rewrites its own state.
  always_comb begin
    o__atom_constant = '0;
    o__atom_pkt_1    = '0;
    o__atom_sel1     = 1'b0;
    o__atom_sel2     = 1'b0;
    if (issue) begin
      o__atom_constant = i__cfg_constant;
      o__atom_pkt_1    = pkt_mem[rd_ptr];
      o__atom_sel1     = sel1_mem[rd_ptr];
      o__atom_sel2     = sel2_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_read_q  <= '0;
      out_write_q <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_read_q  <= i__atom_read;
      out_write_q <= i__atom_write;
    end else if (bus.i__out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.o__out_valid = out_valid_q;
  assign bus.o__out_read  = out_read_q;
  assign bus.o__out_write = out_write_q;

`ifdef ATOM_ISSUE_STAGE_STATS_EN
  logic [31:0] issue_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     issue_cnt <= '0;
    else if (issue) issue_cnt <= issue_cnt + 32'd1;
  end

  assign o__issue_count = issue_cnt;
`endif

endmodule

// File: tb/tb_atom_issue_stage.sv
// Directed + random bench for atom_issue_stage with a behavioural atom and a
// result scoreboard.
module tb_atom_issue_stage;
  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] cfg_constant;
  logic [W-1:0] atom_constant;
  logic [W-1:0] atom_pkt;
  logic         atom_sel1;
  logic         atom_sel2;
  logic [W-1:0] atom_read;
  logic [W-1:0] atom_write;
  logic [W-1:0] atom_state;
  logic         atom_load;
  logic [W-1:0] atom_load_val;
`ifdef ATOM_ISSUE_STAGE_STATS_EN
  logic [31:0]  issue_count;
`endif

  atom_issue_stage_if #(.COUNT_WIDTH(W)) bus ();

  atom_issue_stage #(.COUNT_WIDTH(W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus.slave),
    .i__cfg_constant  (cfg_constant),
    .o__atom_constant (atom_constant),
    .o__atom_pkt_1    (atom_pkt),
    .o__atom_sel1     (atom_sel1),
    .o__atom_sel2     (atom_sel2),
    .i__atom_read     (atom_read),
    .i__atom_write    (atom_write)
`ifdef ATOM_ISSUE_STAGE_STATS_EN
    ,
    .o__issue_count   (issue_count)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- atom model ----------------
  function automatic logic [W-1:0] atom_f(input logic [W-1:0] st, input logic [W-1:0] pkt,
                                          input logic s1, input logic s2, input logic [W-1:0] cst);
    logic [W-1:0] base;
    logic [W-1:0] opnd;
    base = s2 ? '0 : st;
    opnd = s1 ? pkt : cst;
    return base + opnd;
  endfunction

  assign atom_read  = atom_state;
  assign atom_write = atom_f(atom_state, atom_pkt, atom_sel1, atom_sel2, atom_constant);

  always @(posedge clk) begin
    if (atom_load) atom_state <= atom_load_val;
    else           atom_state <= atom_write;
  end

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   m_state;
  int             chk_cnt = 0;
  int             err_cnt = 0;
  int             acc_total = 0;

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    chk_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.o__out_valid && bus.i__out_ready) begin
      chk_cnt++;
      assert (exp_q.size() != 0) else begin
        err_cnt++;
        $error("FAIL result_unexpected observed=%0h expected=none",
               {bus.o__out_read, bus.o__out_write});
      end
      if (exp_q.size() != 0)
        chk("result_pair", {bus.o__out_read, bus.o__out_write}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic try_push(input logic [W-1:0] pkt, input logic s1, input logic s2, output logic acc);
    logic [W-1:0] nw;
    bus.i__in_valid = 1'b1;
    bus.i__in_pkt   = pkt;
    bus.i__in_sel1  = s1;
    bus.i__in_sel2  = s2;
    @(negedge clk);
    acc = bus.o__in_ready;
    if (acc) begin
      nw = atom_f(m_state, pkt, s1, s2, cfg_constant);
      exp_q.push_back({m_state, nw});
      m_state = nw;
      acc_total++;
    end
    step();
    bus.i__in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !bus.o__out_valid) break;
      step();
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  task automatic load_atom(input logic [W-1:0] v);
    atom_load     = 1'b1;
    atom_load_val = v;
    step();
    atom_load = 1'b0;
    m_state   = v;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       acc;
    logic [3:0] acc_v;

    rst_n            = 1'b0;
    bus.i__in_valid  = 1'b0;
    bus.i__in_pkt    = '0;
    bus.i__in_sel1   = 1'b0;
    bus.i__in_sel2   = 1'b0;
    bus.i__out_ready = 1'b0;
    cfg_constant     = 32'd5;
    atom_load        = 1'b1;
    atom_load_val    = 32'd7;
    m_state          = 32'd7;
    repeat (3) step();

    chk("rst_out_valid", bus.o__out_valid, 0);
    chk("rst_in_ready", bus.o__in_ready, 1);
    chk("rst_out_pair", {bus.o__out_read, bus.o__out_write}, 0);
    chk("rst_atom_noop", {atom_constant, atom_pkt, atom_sel1, atom_sel2}, 0);

    @(negedge clk);
    rst_n     = 1'b1;
    atom_load = 1'b0;
    step();

    // state 7, constant 5, pkt 10 add-packet
    try_push(32'd10, 1'b1, 1'b0, acc);
    chk("t1_accept", acc, 1);
    chk("t1_valid_early", bus.o__out_valid, 0);
    step();
    chk("t1_valid", bus.o__out_valid, 1);
    chk("t1_pair", {bus.o__out_read, bus.o__out_write}, {32'd7, 32'd17});
    step();
    chk("t1_hold", {bus.o__out_valid, bus.o__out_read, bus.o__out_write}, {1'b1, 32'd7, 32'd17});
    bus.i__out_ready = 1'b1;
    step();
    chk("t1_valid_clear", bus.o__out_valid, 0);
    chk("t1_atom_state", atom_state, 32'd17);

    // constant-only write
    try_push(32'd99, 1'b0, 1'b1, acc);
    step();
    chk("t2_pair", {bus.o__out_read, bus.o__out_write}, {32'd17, 32'd5});
    drain();
    chk("t2_atom_state", atom_state, 32'd5);

    // modular wrap passes through
    load_atom(32'hFFFF_FFF0);
    try_push(32'h20, 1'b1, 1'b0, acc);
    drain();
    chk("wrap_atom_state", atom_state, 32'h10);

    // back-pressure: 4 pushes, 3 fit
    bus.i__out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      try_push($urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
      acc_v[i] = acc;
    end
    chk("bp_accepts", acc_v, 4'b0111);
    chk("bp_in_ready", bus.o__in_ready, 0);
    bus.i__out_ready = 1'b1;
    drain();

    // idle: atom sees no-op every cycle
    load_atom(32'd42);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_noop", {atom_constant, atom_pkt, atom_sel1, atom_sel2, bus.o__out_valid}, 0);
    end
    step();
    chk("idle_state", atom_state, 32'd42);

    // random traffic with random back-pressure
    for (int i = 0; i < 24; i++) begin
      bus.i__out_ready = 1'($urandom_range(0, 1));
      try_push($urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
    end
    bus.i__out_ready = 1'b1;
    drain();
`ifdef ATOM_ISSUE_STAGE_STATS_EN
    chk("stats_count", issue_count, acc_total);
`endif

    // reset with 2 buffered + 1 pending result
    bus.i__out_ready = 1'b0;
    for (int i = 0; i < 3; i++) try_push(32'd1000 + i, 1'b1, 1'b0, acc);
    chk("pre_rst_full", bus.o__in_ready, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.o__out_valid, 0);
    chk("mid_rst_in_ready", bus.o__in_ready, 1);
    chk("mid_rst_noop", {atom_constant, atom_pkt, atom_sel1, atom_sel2}, 0);
    exp_q.delete();
    acc_total = 0;
    repeat (2) step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    m_state = atom_state;
    bus.i__out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_stale", bus.o__out_valid, 0);
      step();
    end
    try_push(32'd3, 1'b1, 1'b0, acc);
    drain();

`ifdef ATOM_ISSUE_STAGE_STATS_EN
    force dut.issue_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.issue_cnt;
    try_push(32'd1, 1'b1, 1'b0, acc);
    try_push(32'd2, 1'b1, 1'b0, acc);
    drain();
    chk("stats_wrap", issue_count, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
